scalar_arbiter: RTL

SCALAR_ARBITER -- requirements
Module: scalar_arbiter

---
 rtl/scalar_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/scalar_arbiter.sv
// scalar_arbiter: round-robin arbiter granting NREQ requesters exclusive use of
// one shared scalar arithmetic unit. Issues one operation at a time, forwards
// the result handshake to the owner and aborts with a sticky error flag if the
// unit does not deliver a result within TIMEOUT cycles.
module scalar_arbiter #(
   parameter int NREQ    = 4,
   parameter int IDW     = $clog2(NREQ),
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [2*NREQ-1:0] req_mode,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   resp_valid,
   input  logic [NREQ-1:0]   resp_ready,
   output logic [IDW-1:0]    grant_id,
   output logic              busy,
   output logic [1:0]        unit_mode,
   output logic              unit_input_ready,
   output logic              unit_output_taken,
   input  logic [1:0]        unit_state,
   output logic              err,
   output logic [IDW-1:0]    err_id,
   input  logic              err_clr
);

   localparam int          TCW    = $clog2(TIMEOUT) + 1;
   localparam int unsigned NREQ_U = NREQ;

   localparam logic [1:0] UNIT_IDLE = 2'b00;
   localparam logic [1:0] UNIT_HELD = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t           r_state;
   logic [IDW-1:0]   r_rr_ptr;
   logic [IDW-1:0]   r_grant_id;
   logic [1:0]       r_mode_q;
   logic [TCW-1:0]   r_tcnt;
   logic             r_err;
   logic [IDW-1:0]   r_err_id;

   logic             w_any;
   logic [IDW-1:0]   w_winner;
   logic             w_issue;
   logic             w_owner_valid;
   logic             w_taken;
   logic             w_timeout;
   logic [IDW-1:0]   w_next_ptr;

   // Round-robin search: first requester at or after r_rr_ptr, wrapping modulo NREQ.
   always_comb begin
      w_any    = 1'b0;
      w_winner = '0;
      for (int unsigned k = 0; k < NREQ_U; k++) begin
         if (!w_any && req_valid[(32'(r_rr_ptr) + k) % NREQ_U]) begin
            w_any    = 1'b1;
            w_winner = IDW'((32'(r_rr_ptr) + k) % NREQ_U);
         end
      end
   end

   // Issue is gated by reset so no acceptance pulse can escape while reset is held.
   assign w_issue       = reset && (r_state == ST_IDLE) && w_any && (unit_state == UNIT_IDLE);
   assign w_owner_valid = (r_state == ST_WAIT) && (unit_state == UNIT_HELD);
   assign w_taken       = w_owner_valid && resp_ready[r_grant_id];
   assign w_timeout     = (r_state == ST_WAIT) && !w_taken && (r_tcnt == TCW'(TIMEOUT - 1));
   assign w_next_ptr    = (r_grant_id == IDW'(NREQ - 1)) ? '0 : r_grant_id + 1'b1;

   // One-hot handshake strobes towards the winner (issue) and the owner (result).
   always_comb begin
      req_ready  = '0;
      resp_valid = '0;
      if (w_issue) begin
         req_ready[w_winner] = 1'b1;
      end
      if (w_owner_valid) begin
         resp_valid[r_grant_id] = 1'b1;
      end
   end

   assign unit_input_ready  = w_issue;
   assign unit_output_taken = w_taken;
   assign busy              = (r_state == ST_WAIT);
   assign grant_id          = r_grant_id;
   assign unit_mode         = r_mode_q;
   assign err               = r_err;
   assign err_id            = r_err_id;

   // Arbitration FSM, timeout counter and sticky error flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_rr_ptr   <= '0;
         r_grant_id <= '0;
         r_mode_q   <= 2'b00;
         r_tcnt     <= '0;
         r_err      <= 1'b0;
         r_err_id   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_issue) begin
                  r_grant_id <= w_winner;
                  r_mode_q   <= req_mode[2*w_winner +: 2];
                  r_tcnt     <= '0;
                  r_state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (w_taken || w_timeout) begin
                  r_state  <= ST_IDLE;
                  r_rr_ptr <= w_next_ptr;
               end else begin
                  r_tcnt <= r_tcnt + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
         // A timeout in the same cycle as err_clr keeps the flag set.
         if (w_timeout) begin
            r_err    <= 1'b1;
            r_err_id <= r_grant_id;
         end else if (err_clr) begin
            r_err <= 1'b0;
         end
      end
   end

endmodule
